// File: rtl/jump_fetch_sequencer_if.sv
// Handshake and control-bus bundle between the instruction decoder, the jump
// fetch sequencer and the register/control bus it strobes.
interface jump_fetch_sequencer_if;
    logic start;
    logic is_call;
    logic cond_true;
    logic busy;
    logic done;
    logic sel_pc;
    logic sel_inc;
    logic sel_j;
    logic mem_read;
    logic ld_inc;
    logic ld_pc;
    logic ld_j1;
    logic ld_j2;
    logic ld_xy;

    // Decoder / bench side: issues requests, observes the control bus.
    modport master (
        output start,
        output is_call,
        output cond_true,
        input  busy,
        input  done,
        input  sel_pc,
        input  sel_inc,
        input  sel_j,
        input  mem_read,
        input  ld_inc,
        input  ld_pc,
        input  ld_j1,
        input  ld_j2,
        input  ld_xy
    );

    // Sequencer side: accepts requests, drives the control bus.
    modport slave (
        input  start,
        input  is_call,
        input  cond_true,
        output busy,
        output done,
        output sel_pc,
        output sel_inc,
        output sel_j,
        output mem_read,
        output ld_inc,
        output ld_pc,
        output ld_j1,
        output ld_j2,
        output ld_xy
    );
endinterface

// File: rtl/jump_fetch_sequencer.sv
// Sequencer for 16-bit-immediate GOTO/CALL: fetches J1/J2 behind the opcode,
// advances PC past each byte, then optionally saves the return address and jumps.
module jump_fetch_sequencer #(
    parameter int PHASE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    jump_fetch_sequencer_if.slave   bus
);

    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH_HI = 4'd1,
        S_INC1     = 4'd2,
        S_STORE1   = 4'd3,
        S_FETCH_LO = 4'd4,
        S_INC2     = 4'd5,
        S_STORE2   = 4'd6,
        S_SAVE_RET = 4'd7,
        S_JUMP     = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            r_call;
    logic            w_last;
    logic            w_in_phase;

    logic            w_busy;
    logic            w_done;
    logic            w_sel_pc;
    logic            w_sel_inc;
    logic            w_sel_j;
    logic            w_mem_read;
    logic            w_ld_inc;
    logic            w_ld_pc;
    logic            w_ld_j1;
    logic            w_ld_j2;
    logic            w_ld_xy;

    assign w_last     = (r_cnt == LAST);
    assign w_in_phase = (r_state != S_IDLE) && (r_state != S_DONE);

    // The counter restarts at zero whenever the state changes, so every phase
    // is exactly PHASE_CYCLES long regardless of how it was entered.
    assign w_cnt_next = (!w_in_phase || (w_next != r_state)) ? '0 : r_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_call  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if ((r_state == S_IDLE) && bus.start) begin
                r_call <= bus.is_call;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.start) w_next = S_FETCH_HI;
            S_FETCH_HI: if (w_last)    w_next = S_INC1;
            S_INC1:     if (w_last)    w_next = S_STORE1;
            S_STORE1:   if (w_last)    w_next = S_FETCH_LO;
            S_FETCH_LO: if (w_last)    w_next = S_INC2;
            S_INC2:     if (w_last)    w_next = S_STORE2;
            S_STORE2: begin
                // Branch condition is only meaningful once both bytes are in J.
                if (w_last) begin
                    if (!bus.cond_true) begin
                        w_next = S_DONE;
                    end else if (r_call) begin
                        w_next = S_SAVE_RET;
                    end else begin
                        w_next = S_JUMP;
                    end
                end
            end
            S_SAVE_RET: if (w_last)    w_next = S_JUMP;
            S_JUMP:     if (w_last)    w_next = S_DONE;
            S_DONE:                    w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_done     = 1'b0;
        w_sel_pc   = 1'b0;
        w_sel_inc  = 1'b0;
        w_sel_j    = 1'b0;
        w_mem_read = 1'b0;
        w_ld_inc   = 1'b0;
        w_ld_pc    = 1'b0;
        w_ld_j1    = 1'b0;
        w_ld_j2    = 1'b0;
        w_ld_xy    = 1'b0;
        // Sources stay driven for the whole phase; the load is a single-cycle
        // strobe on the final settle cycle.
        case (r_state)
            S_FETCH_HI: begin
                w_sel_pc   = 1'b1;
                w_mem_read = 1'b1;
                w_ld_j1    = w_last;
            end
            S_INC1, S_INC2: begin
                w_sel_pc   = 1'b1;
                w_ld_inc   = w_last;
            end
            S_STORE1, S_STORE2: begin
                w_sel_inc  = 1'b1;
                w_ld_pc    = w_last;
            end
            S_FETCH_LO: begin
                w_sel_pc   = 1'b1;
                w_mem_read = 1'b1;
                w_ld_j2    = w_last;
            end
            S_SAVE_RET: begin
                w_sel_inc  = 1'b1;
                w_ld_xy    = w_last;
            end
            S_JUMP: begin
                w_sel_j    = 1'b1;
                w_ld_pc    = w_last;
            end
            S_DONE: begin
                w_done     = 1'b1;
            end
            default: begin
                w_done     = 1'b0;
            end
        endcase
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.sel_pc   = w_sel_pc;
    assign bus.sel_inc  = w_sel_inc;
    assign bus.sel_j    = w_sel_j;
    assign bus.mem_read = w_mem_read;
    assign bus.ld_inc   = w_ld_inc;
    assign bus.ld_pc    = w_ld_pc;
    assign bus.ld_j1    = w_ld_j1;
    assign bus.ld_j2    = w_ld_j2;
    assign bus.ld_xy    = w_ld_xy;

endmodule

// File: tb/tb_jump_fetch_sequencer.sv
// Bench for jump_fetch_sequencer: two instances (4 and 2 cycles per phase) checked
// cycle by cycle against a phase-schedule model, with random noise on ignored inputs.
module tb_jump_fetch_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    jump_fetch_sequencer_if ifa ();
    jump_fetch_sequencer_if ifb ();

    jump_fetch_sequencer #(.PHASE_CYCLES(4)) u_p4 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    jump_fetch_sequencer #(.PHASE_CYCLES(2)) u_p2 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    // Bit order: busy done sel_pc sel_inc sel_j mem_read ld_inc ld_pc ld_j1 ld_j2 ld_xy
    function automatic logic [10:0] pack(int which);
        if (which == 0)
            return {ifa.busy, ifa.done, ifa.sel_pc, ifa.sel_inc, ifa.sel_j, ifa.mem_read,
                    ifa.ld_inc, ifa.ld_pc, ifa.ld_j1, ifa.ld_j2, ifa.ld_xy};
        return {ifb.busy, ifb.done, ifb.sel_pc, ifb.sel_inc, ifb.sel_j, ifb.mem_read,
                ifb.ld_inc, ifb.ld_pc, ifb.ld_j1, ifb.ld_j2, ifb.ld_xy};
    endfunction

    // Expected control word k cycles after the accepting edge: the sequence is a
    // list of P-cycle phases followed by one DONE cycle, then IDLE.
    function automatic logic [10:0] model(int p, int k, bit call, bit cond);
        logic [10:0] v;
        int nph;
        int dk;
        int ph;
        bit last;
        v   = '0;
        nph = cond ? (call ? 8 : 7) : 6;
        dk  = nph * p + 1;
        if (k == dk) return 11'b110_0000_0000;
        if (k < 1 || k > dk) return '0;
        ph   = (k - 1) / p;
        last = ((k - 1) % p) == (p - 1);
        v[10] = 1'b1;
        if (ph == 0 || ph == 3) begin
            v[8] = 1'b1;
            v[5] = 1'b1;
            if (ph == 0) v[2] = last;
            else         v[1] = last;
        end else if (ph == 1 || ph == 4) begin
            v[8] = 1'b1;
            v[4] = last;
        end else if (ph == 2 || ph == 5) begin
            v[7] = 1'b1;
            v[3] = last;
        end else if (ph == 6 && call) begin
            v[7] = 1'b1;
            v[0] = last;
        end else begin
            v[6] = 1'b1;
            v[3] = last;
        end
        return v;
    endfunction

    task automatic drive(int which, logic s, logic c, logic cnd);
        if (which == 0) begin
            ifa.start = s; ifa.is_call = c; ifa.cond_true = cnd;
        end else begin
            ifb.start = s; ifb.is_call = c; ifb.cond_true = cnd;
        end
    endtask

    task automatic check(string tag, logic [10:0] obs, logic [10:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_onehot(string tag, logic [10:0] obs);
        tests++;
        assert ($onehot0(obs[8:6]) && $onehot0(obs[4:0])) else begin
            fails++;
            $error("FAIL %s onehot observed=%b expected at most one select and one load", tag, obs);
        end
    endtask

    // Entered in an IDLE cycle between negedge and posedge; returns in the IDLE
    // cycle right after DONE, so a following call exercises earliest re-accept.
    task automatic run(int which, bit call, bit cond, string tag);
        int p;
        int dk;
        logic [10:0] obs;
        p  = (which == 0) ? 4 : 2;
        dk = (cond ? (call ? 8 : 7) : 6) * p + 1;
        check($sformatf("%s:idle", tag), pack(which), '0);
        drive(which, 1'b1, call, 1'($urandom_range(0, 1)));
        for (int k = 1; k <= dk + 1; k++) begin
            @(negedge clk);
            obs = pack(which);
            check($sformatf("%s:c%0d", tag, k), obs, model(p, k, call, cond));
            check_onehot($sformatf("%s:c%0d", tag, k), obs);
            if (k == dk + 1)
                drive(which, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                drive(which, (k == 10 || k == dk) ? 1'b1 : 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      (k == 6 * p) ? 1'(cond) : 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_p4", pack(0), '0);
        check("reset_p2", pack(1), '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run(0, 1'b0, 1'b1, "T1_goto");
        run(0, 1'b0, 1'b0, "T2_nottaken");
        run(0, 1'b1, 1'b1, "T3_call");
        run(0, 1'b1, 1'b0, "T3_call_nottaken");

        // Abort in the middle of FETCH_LO, before its ld_j2 strobe.
        check("T5:idle", pack(0), '0);
        drive(0, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("T5:c%0d", k), pack(0), model(4, k, 1'b0, 1'b1));
            drive(0, 1'b0, 1'b0, 1'b1);
        end
        #2 reset = 1'b1;
        #1;
        check("T5:async_p4", pack(0), '0);
        check("T5:async_p2", pack(1), '0);
        repeat (2) begin
            @(negedge clk);
            check("T5:held", pack(0), '0);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("T5:released", pack(0), '0);
        end
        run(0, 1'b0, 1'b1, "T5_restart");

        run(1, 1'b0, 1'b1, "T6_goto");
        run(1, 1'b1, 1'b1, "T6_call");
        run(1, 1'b0, 1'b0, "T6_nottaken");

        for (int i = 0; i < 16; i++) begin
            run(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $sformatf("R%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
